// File: rtl/uart_pkg.sv
// =============================================================
// uart_pkg : shared frame-format types and constants for the UART
// Rev 1.0
// =============================================================
`default_nettype none

package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

   localparam int OVERSAMPLE = 16;
   localparam int DATA_BITS  = 8;

endpackage

`default_nettype wire

// File: rtl/uart_rx_tick_gen.sv
// =============================================================
// uart_rx_tick_gen : free-running 16x baud oversample tick divider
// Rev 1.0
// =============================================================
`default_nettype none

module uart_rx_tick_gen
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 9600
) (
   input  logic clk,
   input  logic rst,
   output logic s_tick
);

   localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
   // Keep at least one counter bit so DIV == 1 still elaborates.
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] c_LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = (cnt_q == c_LAST) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign s_tick = (cnt_q == c_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// =============================================================
// uart_rx : 8N1 serial receiver, 16x oversampled, mid-bit sampling
// Rev 1.0
// =============================================================
`default_nettype none

module uart_rx #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_done,
   output logic       rx_busy,
   output logic       frame_err
);

   import uart_pkg::*;

   localparam logic [3:0] c_MID      = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0] c_LAST     = 4'(OVERSAMPLE - 1);
   localparam logic [2:0] c_LAST_BIT = 3'(DATA_BITS - 1);

   logic                 sync1_q, rx_s_q;
   logic                 s_tick;
   rx_state_t            state_q, state_d;
   logic [3:0]           tick_q, tick_d;
   logic [2:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 done_q, done_d;
   logic                 ferr_q, ferr_d;

   uart_rx_tick_gen #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) u_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .s_tick (s_tick)
   );

   // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         sync1_q <= rx;
         rx_s_q  <= sync1_q;
      end
   end

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      data_d  = data_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s_q) begin
               state_d = START;
               tick_d  = '0;
            end
         end
         START: begin
            if (s_tick) begin
               if (tick_q == c_MID) begin
                  tick_d  = '0;
                  bit_d   = '0;
                  state_d = rx_s_q ? IDLE : DATA;
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (tick_q == c_LAST) begin
                  sh_d   = {rx_s_q, sh_q[DATA_BITS-1:1]};
                  tick_d = '0;
                  if (bit_q == c_LAST_BIT) begin
                     state_d = STOP;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
         end
         STOP: begin
            // Leaving in mid stop bit lets a zero-gap next start edge be caught.
            if (s_tick) begin
               if (tick_q == c_LAST) begin
                  tick_d  = '0;
                  state_d = IDLE;
                  if (rx_s_q) begin
                     data_d = sh_q;
                     done_d = 1'b1;
                  end else begin
                     ferr_d = 1'b1;
                  end
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
      end
   end

   assign rx_data   = data_q;
   assign rx_done   = done_q;
   assign frame_err = ferr_q;
   assign rx_busy   = (state_q != IDLE);

endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver forming the receive side of the team's UART: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line. It synchronizes the `rx` pin, oversamples at 16x the baud rate, validates the start bit, and samples each bit at mid-bit. It presents each good byte with a one-cycle `rx_done` strobe and flags bad stop bits via `frame_err`. It sits beside the existing transmitter under a future full-duplex UART top and shares its frame format.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line baud rate.
- `OVERSAMPLE`, default 16: samples per bit. Fixed at 16; other values are unsupported.
- `clk` input, 1 bit: system clock; all logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-low reset.
- `rx` input, 1 bit: asynchronous serial line, idle high.
- `rx_data` output, 8 bits: last correctly framed byte; holds until the next good frame.
- `rx_done` output, 1 bit: one-cycle strobe; `rx_data` is new this cycle.
- `rx_busy` output, 1 bit: high from start-edge detection until return to IDLE.
- `frame_err` output, 1 bit: one-cycle strobe when the sampled stop bit is 0.

## Operation
- **Synchronizer:** 2-flop synchronizer on `rx`, both flops reset to 1. All FSM decisions use the synchronized `rx_s`.
- **Tick generator:** divider `DIV = CLK_FREQ / (BAUD*16)` (integer, truncated); counter 0..DIV-1 free-runs; `s_tick` is high one cycle at wrap.
  - Counter width is `$clog2(DIV)`.
  - The generator is not restarted on start detection. Start-edge alignment error is ≤1 tick (1/16 bit).
- **Counters:** `tick_cnt` is 4 bits; `bit_cnt` is 3 bits; shift register `sh` is 8 bits.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE**
  - `rx_busy` = 0.
  - On `rx_s == 0` (clock cycle, no tick needed): go to START, set `tick_cnt = 0`.
- **START**, on each `s_tick`, `tick_cnt++`:
  - At `tick_cnt == 7` (mid start bit): if `rx_s == 0`, go to DATA with `tick_cnt = 0` and `bit_cnt = 0`. Otherwise treat it as a glitch and go to IDLE; no strobe fires.
- **DATA**, on each `s_tick`, `tick_cnt++`:
  - At `tick_cnt == 15`: `sh <= {rx_s, sh[7:1]}` and `tick_cnt = 0`.
  - If `bit_cnt == 7`, go to STOP; otherwise `bit_cnt++`.
- **STOP**, on each `s_tick`, `tick_cnt++`:
  - At `tick_cnt == 15` (mid stop bit): if `rx_s == 1`, then `rx_data <= sh` and `rx_done` pulses. Otherwise `frame_err` pulses and `rx_data` is unchanged.
  - Either way, go to IDLE.
- **Back-to-back frames:** the FSM returns to IDLE in mid stop bit, so a start edge immediately after the stop bit is caught. Back-to-back frames with zero idle gap must be received.
- **Break condition:** if `rx` is held low it produces `frame_err` once. The block then re-enters START on the still-low line, and repeats every ~10 bits until `rx` returns high.
- **Overrun:** there is no overrun detection. The consumer must take `rx_data` before the next `rx_done`.

## Timing
- **Reset values:** `rx_data = 8'h00`, `rx_done = 0`, `rx_busy = 0`, `frame_err = 0`, FSM = IDLE, all counters 0.
- **Reset mid-frame:** reset aborts the frame immediately. No strobe fires and `rx_data` is cleared.
- **Start detection:** a falling edge on `rx` reaches `rx_s` 2 clocks later. `rx_busy` rises on the following clock.
- **Strobe timing:** `rx_done` and `frame_err` are registered. Each is high exactly one clock, the clock after the `s_tick` that samples the stop bit, about 9.5 bit times after the start edge.
- **Strobe exclusivity:** `rx_done` and `frame_err` are never high together.
- **Sampling point:** bit n (0 = LSB) is sampled at 8 + 16·(n+1) ticks after start detection, ±1 tick.

## Structure
- **Package `uart_pkg`:** `typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t`, `localparam OVERSAMPLE = 16`, and `DATA_BITS = 8`. The transmitter adopts the same package later.
- **Sub-module `uart_rx_tick_gen`:** parameters `CLK_FREQ` and `BAUD`; ports `clk`, `rst`, `s_tick`.
- **Top of this block:** `uart_rx` contains the synchronizer, FSM, datapath and output registers, with `uart_rx_tick_gen` instantiated inside it.

## Test plan
All scenarios use `CLK_FREQ = 1_600_000` and `BAUD = 10_000`, giving `DIV = 10` and a bit time of 160 clk.
- **Single byte:** send frame 0xA5 with `rx` idle before and after -> one `rx_done` pulse, `rx_data = 8'hA5`, `frame_err` stays 0, and `rx_busy` falls ~1520 clk after the start edge.
- **Back-to-back:** send 0x00 then 0xFF then 0x81 with no idle gap -> three `rx_done` pulses with `rx_data` 0x00, 0xFF, 0x81 in order.
- **Start glitch:** drive `rx` low for 40 clk (≈4 ticks), then high -> `rx_busy` pulses, no `rx_done`, no `frame_err`, `rx_data` unchanged.
- **Framing error:** send byte 0x3C with the stop bit driven 0, then `rx` high -> one `frame_err` pulse, no `rx_done`, and `rx_data` keeps its previous value.
- **Reset mid-frame:** assert `rst = 0` for 2 clk during data bit 4 of 0x5A, release, then send 0xC3 -> no strobe for the aborted frame, `rx_data = 8'h00` after reset, then `rx_data = 8'hC3` with one `rx_done`.
- **Baud skew:** send 0x96 with the bit time stretched to 166 clk (+3.75 %) -> `rx_data = 8'h96` received correctly.
